// File: rtl/decoded_inst_queue.sv
// rtl/decoded_inst_queue.sv - circular FIFO of packed decoded-instruction words, unpacked at the head
`ifndef DECODED_INST_DEFS
`define DECODED_INST_DEFS
`define OPCODE_WIDTH 7
`define INST_TYPE_SIGNAL_WIDTH 4
`define REG_ADDR_SIZE 5
`define IMM_WIDTH 32
`define VALUE_WIDTH 32
`define PC_WIDTH 32
`define DECODED_INST_WORD_WIDTH (6 + `OPCODE_WIDTH + `INST_TYPE_SIGNAL_WIDTH + 3*`REG_ADDR_SIZE + `IMM_WIDTH + `VALUE_WIDTH + `PC_WIDTH)
`endif

module decoded_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  in_valid,
    input  logic [`DECODED_INST_WORD_WIDTH-1:0]   in_word,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  use_rs1,
    output logic                                  use_rs2,
    output logic                                  use_rd,
    output logic                                  use_imm,
    output logic                                  read_mem,
    output logic                                  write_mem,
    output logic [`OPCODE_WIDTH-1:0]              decoded_opcode,
    output logic [`INST_TYPE_SIGNAL_WIDTH-1:0]    inst_type,
    output logic [`REG_ADDR_SIZE-1:0]             rs1_addr,
    output logic [`REG_ADDR_SIZE-1:0]             rs2_addr,
    output logic [`REG_ADDR_SIZE-1:0]             rd_addr,
    output logic [`IMM_WIDTH-1:0]                 imm,
    output logic [`VALUE_WIDTH-1:0]               value,
    output logic [`PC_WIDTH-1:0]                  npc,
    output logic [PTR_W:0]                        count
);

    localparam int              W        = `DECODED_INST_WORD_WIDTH;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    // Ready depends on occupancy only: a full queue never accepts, even while popping.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; writes are suppressed during reset and flush.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) mem_q[wr_ptr_q] <= in_word;
    end

    assign {use_rs1, use_rs2, use_rd, use_imm, read_mem, write_mem,
            decoded_opcode, inst_type, rs1_addr, rs2_addr, rd_addr,
            imm, value, npc} = mem_q[rd_ptr_q];

endmodule
